pdm_mic_capture: RTL and testbench

- Front-end stage that drives the 16-microphone PDM array and feeds the beamformer core.
- Generates the shared PDM bit clock and samples 8 data pins, each shared by a left/right mic pair.
- Assembles one 16-bit mic word per PDM period and delivers it over valid/ready.
- Tags every DECIM-th word as the frame boundary. The core uses this as its decimation (lr) strobe.

---
 rtl/pdm_mic_capture.sv | 134 +++++++++++++
 tb/tb_pdm_mic_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_capture.sv
// PDM array front end: drives pdm_clk, samples 8 shared L/R pins, assembles one 16-bit mic word per PDM period.
// Latency 1 clk after the odd-half capture; no stall: a word that finds the output busy is dropped and sets overflow.
module pdm_mic_capture #(
  parameter int CLK_DIV = 8,
  parameter int DECIM   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  pdm_data,
  output logic        pdm_clk,
  output logic [15:0] mic_bits,
  output logic        bits_valid,
  input  logic        bits_ready,
  output logic        frame_last,
  output logic        overflow,
  input  logic        clear_ovf
);

  localparam int PH_W = $clog2(CLK_DIV);
  localparam int DC_W = $clog2(DECIM);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0] PH_EVEN = PH_W'(CLK_DIV / 2 - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECIM - 1);

  logic [7:0]      sync1;
  logic [7:0]      sync2;
  logic [PH_W-1:0] phase;
  logic [7:0]      shadow_even;
  logic [15:0]     word_asm;
  logic [15:0]     word_q;
  logic            word_done;
  logic [DC_W-1:0] decim_cnt;
  logic            load_evt;
  logic            out_free;
  logic            accept;
  logic            drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pdm_data;
      sync2 <= sync1;
    end
  end

  // pdm_clk lags phase by one cycle, so it rises on the first edge after en goes high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      phase   <= '0;
      pdm_clk <= 1'b0;
    end else begin
      phase   <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      pdm_clk <= (phase < PH_HALF);
    end
  end

  always_comb begin
    word_asm = '0;
    for (int i = 0; i < 8; i++) begin
      word_asm[2*i]   = shadow_even[i];
      word_asm[2*i+1] = sync2[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_even <= '0;
      word_q      <= '0;
      word_done   <= 1'b0;
    end else if (!en) begin
      shadow_even <= '0;
      word_done   <= 1'b0;
    end else begin
      word_done <= (phase == PH_LAST);
      if (phase == PH_EVEN) begin
        shadow_even <= sync2;
      end
      if (phase == PH_LAST) begin
        word_q <= word_asm;
      end
    end
  end

  always_comb begin
    load_evt = en && word_done;
    out_free = !bits_valid || bits_ready;
    accept   = load_evt && out_free;
    drop     = load_evt && !out_free;
  end

  // Dropped words still advance the frame position so frame tags stay aligned to PDM time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_cnt <= '0;
    end else if (!en) begin
      decim_cnt <= '0;
    end else if (load_evt) begin
      decim_cnt <= (decim_cnt == DC_LAST) ? '0 : decim_cnt + DC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mic_bits   <= '0;
      frame_last <= 1'b0;
      bits_valid <= 1'b0;
    end else if (accept) begin
      mic_bits   <= word_q;
      frame_last <= (decim_cnt == DC_LAST);
      bits_valid <= 1'b1;
    end else if (bits_valid && bits_ready) begin
      frame_last <= 1'b0;
      bits_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Scoreboard bench for pdm_mic_capture: a PDM driver follows pdm_clk, expected words are queued at
// word completion and checked every cycle against the output register, plus directed checks.
module tb_pdm_mic_capture;

  localparam int CLK_DIV = 8;
  localparam int DECIM   = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  pdm_data;
  logic        pdm_clk;
  logic [15:0] mic_bits;
  logic        bits_valid;
  logic        bits_ready;
  logic        frame_last;
  logic        overflow;
  logic        clear_ovf;

  pdm_mic_capture #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pdm_data   (pdm_data),
    .pdm_clk    (pdm_clk),
    .mic_bits   (mic_bits),
    .bits_valid (bits_valid),
    .bits_ready (bits_ready),
    .frame_last (frame_last),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] w;
    logic        fl;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic       fix_mode = 1'b0;
  logic [7:0] cur_hi   = 8'h00;
  logic [7:0] cur_lo   = 8'h00;
  logic       prev_pdm = 1'b0;
  int         st       = 0;
  int         wcnt     = 0;
  logic       ovf_exp  = 1'b0;
  logic       pending;
  logic       drop;
  exp_t       e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ilv(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w;
    for (int i = 0; i < 8; i++) begin
      w[2*i]   = hi[i];
      w[2*i+1] = lo[i];
    end
    return w;
  endfunction

  // Driver + scoreboard: a pdm_clk rise after a low half marks a completed word at that edge
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      q.delete();
      ovf_exp  = 1'b0;
      st       = 0;
      wcnt     = 0;
      prev_pdm = 1'b0;
    end else begin
      pending = (q.size() > 0);
      drop    = 1'b0;
      if (pending && bits_ready) void'(q.pop_front());
      if (!en) begin
        st   = 0;
        wcnt = 0;
      end else if (pdm_clk && !prev_pdm) begin
        if (st == 2) begin
          e.w  = ilv(cur_hi, cur_lo);
          e.fl = (wcnt == DECIM - 1);
          wcnt = (wcnt + 1) % DECIM;
          if (pending && !bits_ready) drop = 1'b1;
          else q.push_back(e);
        end
        st = 1;
        if (fix_mode) begin
          cur_hi = 8'hA5;
          cur_lo = 8'h3C;
        end else begin
          cur_hi = 8'($urandom_range(0, 255));
          cur_lo = 8'($urandom_range(0, 255));
        end
      end else if (!pdm_clk && st == 1) begin
        st = 2;
      end
      if (drop) ovf_exp = 1'b1;
      else if (clear_ovf) ovf_exp = 1'b0;
      prev_pdm = pdm_clk;
    end
    pdm_data = pdm_clk ? cur_hi : cur_lo;
    chk("valid", 32'(bits_valid), 32'(q.size() > 0));
    chk("ovf", 32'(overflow), 32'(ovf_exp));
    if (q.size() > 0) begin
      chk("word", 32'(mic_bits), 32'(q[0].w));
      chk("flast", 32'(frame_last), 32'(q[0].fl));
    end
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!bits_valid && n < 100);
    chk(tag, 32'(bits_valid), 32'd1);
  endtask

  task automatic wait_pending(input string tag);
    int n = 0;
    while (q.size() == 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, 32'(bits_valid), 32'd1);
  endtask

  initial begin
    int nv;
    int n;
    rst_n      = 1'b0;
    en         = 1'b0;
    bits_ready = 1'b0;
    clear_ovf  = 1'b0;
    pdm_data   = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_pdm", 32'(pdm_clk), 32'd0);
    chk("rst_mic", 32'(mic_bits), 32'd0);
    chk("rst_valid", 32'(bits_valid), 32'd0);
    chk("rst_flast", 32'(frame_last), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed pattern: A5 over high halves, 3C over low halves
    fix_mode   = 1'b1;
    bits_ready = 1'b1;
    en         = 1'b1;
    wait_valid("t2_first");
    nv = 0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #2;
      if (bits_valid) begin
        nv++;
        chk("t2_word", 32'(mic_bits), 32'h4EB1);
      end
    end
    chk("t2_pulses", 32'(nv), 32'd8);
    @(negedge clk);
    fix_mode = 1'b0;

    // Frame tagging from a fresh enable, then again after a 20-clk disable
    en = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b1;
    for (int w = 1; w <= 12; w++) begin
      wait_valid("t3_wait");
      chk("t3_flast", 32'(frame_last), 32'(w % 4 == 0));
    end
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_valid("t3_rewait");
      chk("t3_reen_flast", 32'(frame_last), 32'(w == 4));
    end

    // Backpressure: held word, overflow, recovery, clear
    @(negedge clk);
    bits_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_held", 32'(bits_valid), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd1);
    bits_ready = 1'b1;
    repeat (20) @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("t4_clr", 32'(overflow), 32'd0);

    // Ready rises exactly on the completion edge of a new word while one is pending
    @(negedge clk);
    bits_ready = 1'b0;
    wait_pending("t5_pend");
    n = 0;
    while (pdm_clk && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    bits_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("t5_valid", 32'(bits_valid), 32'd1);
    chk("t5_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);

    // Disable mid-word with a pending word and ready low
    bits_ready = 1'b0;
    wait_pending("t6_pend");
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #2;
    chk("t6_pdm", 32'(pdm_clk), 32'd0);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #2;
      chk("t6_hold", 32'(bits_valid), 32'd1);
    end
    @(negedge clk);
    bits_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_xfer", 32'(bits_valid), 32'd0);
    @(negedge clk);
    en = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!bits_valid && n < 40);
    chk("t6_latency", 32'(n), 32'd9);

    // Asynchronous reset mid-capture with a pending word and overflow set
    @(negedge clk);
    bits_ready = 1'b0;
    wait_pending("t1_pend");
    repeat (10) @(posedge clk);
    #2;
    chk("t1_ovf_pre", 32'(overflow), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_pdm", 32'(pdm_clk), 32'd0);
    chk("t1_mic", 32'(mic_bits), 32'd0);
    chk("t1_valid", 32'(bits_valid), 32'd0);
    chk("t1_flast", 32'(frame_last), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #2;
      chk("t1_pdm_shape", 32'(pdm_clk), 32'(k < 4));
    end
    @(negedge clk);
    bits_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
